// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard and forwarding control.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } hz_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A later-stage write can feed an EX operand only if it really writes a non-x0 register.
   function automatic logic rd_hits(input logic we, input logic [4:0] rd, input logic [4:0] rs);
      return we && (rd != REG_ZERO) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for one EX-stage source register; MEM result beats WB result.
module hazard_fwd_unit
   import hazard_pkg::*;
(
   input  logic [4:0] ex_rs_i,
   input  logic [4:0] mem_rd_i,
   input  logic       mem_we_i,
   input  logic [4:0] wb_rd_i,
   input  logic       wb_we_i,
   output logic [1:0] fwd_sel_o
);

   fwd_sel_t sel;

   always_comb begin
      sel = FWD_RF;
      if (rd_hits(mem_we_i, mem_rd_i, ex_rs_i)) begin
         sel = FWD_EXMEM;
      end else if (rd_hits(wb_we_i, wb_rd_i, ex_rs_i)) begin
         sel = FWD_MEMWB;
      end
   end

   assign fwd_sel_o = sel;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the 5-stage core: multiply stall FSM, load-use stall, jump flush, forwarding.
// Define HAZARD_PERF_EN to add the stall/flush performance counters.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rs1,
   input  logic [4:0]  ex_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_mul,
   input  logic        ex_jump_taken,
   input  logic [4:0]  mem_rd,
   input  logic        mem_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic        wb_reg_write,
   output logic        pc_hold,
   output logic        ifid_hold,
   output logic        ifid_flush,
   output logic        idex_hold,
   output logic        idex_bubble,
   output logic        exmem_bubble,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
`ifdef HAZARD_PERF_EN
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt,
`endif
   output logic        mul_start,
   output logic        mul_done
);

   localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(MUL_LAT - 1);
   localparam logic             MUL_MULTI = (MUL_LAT > 1);

   hz_state_t        state_q;
   logic [CNT_W-1:0] mul_cnt_q;

   logic       mstall, mstart, mdone;
   logic       lu;
   logic       hold_raw, bubble_raw, flush_raw;
   logic [1:0] fwd_a_raw, fwd_b_raw;

   // mul_cnt_q counts EX cycles already spent by the multiply in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         mul_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ex_mul && MUL_MULTI) begin
                  state_q   <= MUL;
                  mul_cnt_q <= CNT_W'(1);
               end
            end
            MUL: begin
               if (mul_cnt_q < MUL_LAST) begin
                  mul_cnt_q <= mul_cnt_q + CNT_W'(1);
               end else begin
                  state_q   <= IDLE;
                  mul_cnt_q <= '0;
               end
            end
            default: begin
               state_q   <= IDLE;
               mul_cnt_q <= '0;
            end
         endcase
      end
   end

   always_comb begin
      mstall = 1'b0;
      mstart = 1'b0;
      mdone  = 1'b0;
      case (state_q)
         IDLE: begin
            mstart = ex_mul;
            mstall = ex_mul && MUL_MULTI;
            mdone  = ex_mul && !MUL_MULTI;
         end
         MUL: begin
            mstall = (mul_cnt_q < MUL_LAST);
            mdone  = !(mul_cnt_q < MUL_LAST);
         end
         default: begin
            mstall = 1'b0;
         end
      endcase
   end

   assign lu = ex_mem_read && (ex_rd != REG_ZERO) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   // A taken jump kills the ID instruction, so its load-use hazard no longer matters.
   always_comb begin
      hold_raw   = 1'b0;
      bubble_raw = 1'b0;
      flush_raw  = 1'b0;
      if (mstall) begin
         hold_raw = 1'b1;
      end else if (ex_jump_taken) begin
         flush_raw  = 1'b1;
         bubble_raw = 1'b1;
      end else if (lu) begin
         hold_raw   = 1'b1;
         bubble_raw = 1'b1;
      end
   end

   hazard_fwd_unit u_fwd_a (
      .ex_rs_i   (ex_rs1),
      .mem_rd_i  (mem_rd),
      .mem_we_i  (mem_reg_write),
      .wb_rd_i   (wb_rd),
      .wb_we_i   (wb_reg_write),
      .fwd_sel_o (fwd_a_raw)
   );

   hazard_fwd_unit u_fwd_b (
      .ex_rs_i   (ex_rs2),
      .mem_rd_i  (mem_rd),
      .mem_we_i  (mem_reg_write),
      .wb_rd_i   (wb_rd),
      .wb_we_i   (wb_reg_write),
      .fwd_sel_o (fwd_b_raw)
   );

   // Every output is quiet while reset is held low.
   assign pc_hold      = rst & hold_raw;
   assign ifid_hold    = rst & hold_raw;
   assign ifid_flush   = rst & flush_raw;
   assign idex_hold    = rst & mstall;
   assign idex_bubble  = rst & bubble_raw;
   assign exmem_bubble = rst & mstall;
   assign mul_start    = rst & mstart;
   assign mul_done     = rst & mdone;
   assign fwd_a        = rst ? fwd_a_raw : 2'd0;
   assign fwd_b        = rst ? fwd_b_raw : 2'd0;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (hold_raw) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (flush_raw) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`else
   // no performance counters in this build
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RISC-V core.
- Sequences the IF/ID, ID/EX and EX/MEM pipeline registers: holds, bubbles and flushes.
- Detects load-use hazards, flushes on taken jumps/branches resolved in EX, and stalls the pipe for multi-cycle multiplies (AluMulSel path) with an internal FSM.
- Generates ALU operand forwarding selects for the EX stage.

Parameters:
- MUL_LAT, 4, EX occupancy in cycles of a multiply; legal 1..16. 1 means no stall.
- CNT_W, 4, multiply counter width; must satisfy 2^CNT_W >= MUL_LAT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  5  source register addresses of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2  in  5  source addresses held in ID/EX
- ex_rd  in  5  destination register in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_mul  in  1  EX instruction uses the multiplier
- ex_jump_taken  in  1  EX resolved a taken jump/branch
- mem_rd  in  5  destination register in MEM
- mem_reg_write  in  1  MEM instruction writes the register file
- wb_rd  in  5  destination register in WB
- wb_reg_write  in  1  WB instruction writes the register file
- pc_hold  out  1  PC keeps its value
- ifid_hold  out  1  IF/ID keeps its contents
- ifid_flush  out  1  IF/ID loads NOP
- idex_hold  out  1  ID/EX keeps its contents
- idex_bubble  out  1  ID/EX loads all-zero control (bubble)
- exmem_bubble  out  1  EX/MEM loads bubble
- fwd_a, fwd_b  out  2  operand source select: 0 = register file, 1 = EX/MEM, 2 = MEM/WB
- mul_start  out  1  first EX cycle of a multiply
- mul_done  out  1  final EX cycle of a multiply

Behaviour:
- State: FSM {IDLE, MUL}, counter mul_cnt[CNT_W-1:0]. Reset sets IDLE and mul_cnt=0.
- While rst=0, all outputs are forced to 0. All outputs are combinational from the registered state and the current inputs.
- **Multiply stall (mstall):**
  - IDLE & ex_mul & MUL_LAT>1: mstall=1, mul_start=1, mul_cnt<=1, go to MUL.
  - MUL & mul_cnt<MUL_LAT-1: mstall=1, mul_cnt++.
  - MUL & mul_cnt==MUL_LAT-1: mstall=0, mul_done=1, mul_cnt<=0, go to IDLE.
  - MUL_LAT==1: mul_start=mul_done=1 in the same cycle; the FSM stays IDLE.
  - Back-to-back multiplies re-enter MUL on the cycle after mul_done.
  - mstall drives pc_hold=ifid_hold=idex_hold=1 and exmem_bubble=1.
- **Load-use (lu):**
  - lu = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - lu drives pc_hold=ifid_hold=1 and idex_bubble=1.
  - One stall cycle only; the consumer later receives the load result via fwd=2.
- **Jump flush:** ex_jump_taken drives ifid_flush=1 and idex_bubble=1. No holds are asserted.
- **Priority:** mstall > ex_jump_taken > lu.
  - lu is ignored when ex_jump_taken=1, because the ID instruction is killed.
  - ex_mul & ex_jump_taken together is illegal; mstall wins, and flush outputs stay 0 until mul_done.
  - idex_hold and idex_bubble are never both 1. ifid_hold and ifid_flush are never both 1.
- **Forwarding (per operand, shown for A):**
  - fwd_a=1 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1.
  - Else fwd_a=2 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
  - Else fwd_a=0.
  - MEM beats WB. x0 is never forwarded.
  - Forwarding stays active during mstall; the upstream register outputs are stable.
- **Reset mid-multiply:** the FSM returns to IDLE immediately. The multiply is abandoned and mul_done is not produced.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments each cycle pc_hold=1.
  - perf_flush_cnt increments each cycle ifid_flush=1.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t: FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2.
  - hz_state_t: IDLE, MUL.
  - Constant REG_ZERO=5'd0.
- One natural sub-module: hazard_fwd_unit, the purely combinational forwarding compare, instantiated once per operand or with both operands inside.
- The FSM and stall logic stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_hold=ifid_hold=idex_bubble=1. Next cycle, with wb_rd=5 and wb_reg_write=1, fwd_a=2.
- Multiply: ex_mul=1 with MUL_LAT=4 -> mul_start in cycle 0, mstall outputs in cycles 0-2, mul_done in cycle 3 with holds 0. A second ex_mul in cycle 4 -> mul_start again.
- Jump: ex_jump_taken=1 while lu conditions also hold -> ifid_flush=1, idex_bubble=1, pc_hold=ifid_hold=0.
- Forward priority: mem_rd=wb_rd=ex_rs2=7, both write enables 1 -> fwd_b=1. With mem_rd=0 (x0) -> fwd_b=2. Both rd=0 -> fwd_b=0.
- Reset mid-multiply: rst low in cycle 1 of a multiply -> all outputs 0 immediately. After release with ex_mul=0 -> IDLE, no mul_done.
- HAZARD_PERF_EN: after the first two scenarios (1 + 3 stall cycles) -> perf_stall_cnt=4, perf_flush_cnt=0. After the jump scenario -> perf_flush_cnt=1.
